// File: rtl/port9_grant_mux.sv
// port9_grant_mux
// Locks a grant to the port picked by the upstream 9-way priority encoder for
// one whole packet. The granted port's beats are muxed into a single
// registered valid/ready output stream. The grant is released on the last
// beat, or on a forced release once MAX_BEATS beats have been sent.
//
// Ports
//   i_clk, i_rst_n     clock (rising edge), synchronous active-low reset
//   i_req/i_data/i_last per-port beat valid, data, last flag
//   i_sel_vld, i_sel   encoder valid and selected port index
//   o_grant            one-hot per-port ready (combinational)
//   o_vld/o_data/o_last/o_port  registered output beat
//   i_rdy              downstream ready
//   o_busy             grant locked
//   o_ovf              one-cycle pulse on a forced (overrun) release
//   o_pkt_cnt          per-port 16-bit saturating packet counters
//                      (present only when PORT9_GRANT_STATS_EN is defined)
//
// States
//   IDLE | no grant held; waiting for a valid encoder select
//   BUSY | grant locked to gport until last beat or overrun
module port9_grant_mux #(
    parameter int DWIDTH    = 64,
    parameter int NPORT     = 9,
    parameter int MAX_BEATS = 16,
    localparam int SW       = $clog2(NPORT),
    localparam int CW       = $clog2(MAX_BEATS + 1)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NPORT-1:0]         i_req,
    input  logic [NPORT*DWIDTH-1:0]  i_data,
    input  logic [NPORT-1:0]         i_last,
    input  logic                     i_sel_vld,
    input  logic [SW-1:0]            i_sel,
    output logic [NPORT-1:0]         o_grant,
    output logic                     o_vld,
    output logic [DWIDTH-1:0]        o_data,
    output logic                     o_last,
    output logic [SW-1:0]            o_port,
    input  logic                     i_rdy,
    output logic                     o_busy,
    output logic                     o_ovf
`ifdef PORT9_GRANT_STATS_EN
    ,
    output logic [NPORT*16-1:0]      o_pkt_cnt
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    logic [SW-1:0]       gport;
    logic [CW-1:0]       cnt;

    logic                ofree;
    logic                g_req;
    logic                g_last;
    logic [DWIDTH-1:0]   g_data;
    logic                s_req;
    logic                sel_ok;
    logic                accept;
    logic                eff_last;

    assign ofree    = !o_vld || i_rdy;
    assign o_busy   = (state == BUSY);
    assign sel_ok   = ({1'b0, i_sel} < (SW+1)'(NPORT));
    assign accept   = (state == BUSY) && g_req && ofree;
    assign eff_last = g_last || (cnt == CW'(MAX_BEATS - 1));

    // Port selection by compare-per-port keeps every index in range, so an
    // encoder index >= NPORT simply matches nothing.
    always_comb begin
        g_req   = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        s_req   = 1'b0;
        o_grant = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (gport == SW'(p)) begin
                g_req  = i_req[p];
                g_last = i_last[p];
                g_data = i_data[p*DWIDTH +: DWIDTH];
                if (state == BUSY && ofree) begin
                    o_grant[p] = 1'b1;
                end
            end
            if (i_sel == SW'(p)) begin
                s_req = i_req[p];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            gport  <= '0;
            cnt    <= '0;
            o_vld  <= 1'b0;
            o_data <= '0;
            o_last <= 1'b0;
            o_port <= '0;
            o_ovf  <= 1'b0;
        end else begin
            o_ovf <= 1'b0;

            case (state)
                IDLE: begin
                    if (i_sel_vld && sel_ok && s_req) begin
                        gport <= i_sel;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (accept) begin
                        cnt <= cnt + CW'(1);
                        if (eff_last) begin
                            state <= IDLE;
                            o_ovf <= !g_last;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            // Output register: a new beat takes priority over draining.
            if (accept) begin
                o_vld  <= 1'b1;
                o_data <= g_data;
                o_last <= eff_last;
                o_port <= gport;
            end else if (o_vld && i_rdy) begin
                o_vld  <= 1'b0;
            end
        end
    end

`ifdef PORT9_GRANT_STATS_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_pkt_cnt <= '0;
        end else if (accept && eff_last) begin
            for (int p = 0; p < NPORT; p++) begin
                if (gport == SW'(p) && o_pkt_cnt[p*16 +: 16] != 16'hFFFF) begin
                    o_pkt_cnt[p*16 +: 16] <= o_pkt_cnt[p*16 +: 16] + 16'd1;
                end
            end
        end
    end
`else
    // Packet statistics not built.
`endif

endmodule

// File: tb/tb_port9_grant_mux.sv
module tb_port9_grant_mux;

    localparam int DW   = 64;
    localparam int NP   = 9;
    localparam int MAXB = 16;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NP-1:0]      req;
    logic [NP*DW-1:0]   data;
    logic [NP-1:0]      last;
    logic               sel_vld;
    logic [3:0]         sel;
    logic [NP-1:0]      o_grant;
    logic               o_vld;
    logic [DW-1:0]      o_data;
    logic               o_last;
    logic [3:0]         o_port;
    logic               rdy;
    logic               o_busy;
    logic               o_ovf;
`ifdef PORT9_GRANT_STATS_EN
    logic [NP*16-1:0]   o_pkt_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    port9_grant_mux #(.DWIDTH(DW), .NPORT(NP), .MAX_BEATS(MAXB)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_data    (data),
        .i_last    (last),
        .i_sel_vld (sel_vld),
        .i_sel     (sel),
        .o_grant   (o_grant),
        .o_vld     (o_vld),
        .o_data    (o_data),
        .o_last    (o_last),
        .o_port    (o_port),
        .i_rdy     (rdy),
        .o_busy    (o_busy),
        .o_ovf     (o_ovf)
`ifdef PORT9_GRANT_STATS_EN
        ,
        .o_pkt_cnt (o_pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: packet-level bookkeeping of who holds the grant,
    // how many beats of the packet have gone out, and what sits in the
    // output slot.
    bit          m_busy;
    int          m_gport;
    int          m_sent;
    bit          m_vld;
    logic [63:0] m_data;
    bit          m_last;
    int          m_port;
    bit          m_ovf;
    int          m_pkt [NP];
    bit          m_slot_free;
    bit          m_end;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_gport = 0; m_sent = 0; m_vld = 0; m_data = '0;
            m_last = 0; m_port = 0; m_ovf = 0;
            for (int p = 0; p < NP; p++) m_pkt[p] = 0;
        end else begin
            m_slot_free = !m_vld || rdy;
            m_ovf = 0;
            if (m_busy && req[m_gport] && m_slot_free) begin
                m_sent = m_sent + 1;
                m_end  = last[m_gport] || (m_sent == MAXB);
                m_vld  = 1;
                m_data = data[m_gport*DW +: DW];
                m_last = m_end;
                m_port = m_gport;
                if (m_end) begin
                    m_busy = 0;
                    m_ovf  = !last[m_gport];
                    if (m_pkt[m_gport] < 65535) m_pkt[m_gport] = m_pkt[m_gport] + 1;
                end
            end else begin
                if (m_vld && rdy) m_vld = 0;
                if (!m_busy && sel_vld && int'(sel) < NP && req[sel]) begin
                    m_busy  = 1;
                    m_gport = int'(sel);
                    m_sent  = 0;
                end
            end
        end
    end

    logic [NP-1:0] exp_grant;
    always @(negedge clk) begin
        if (chk_en) begin
            exp_grant = '0;
            if (m_busy && (!m_vld || rdy)) exp_grant[m_gport] = 1'b1;
            chk("m_grant", 64'(o_grant), 64'(exp_grant));
            chk("m_vld",   64'(o_vld),   64'(m_vld));
            chk("m_data",  o_data,       m_data);
            chk("m_last",  64'(o_last),  64'(m_last));
            chk("m_port",  64'(o_port),  64'(m_port));
            chk("m_busy",  64'(o_busy),  64'(m_busy));
            chk("m_ovf",   64'(o_ovf),   64'(m_ovf));
`ifdef PORT9_GRANT_STATS_EN
            for (int p = 0; p < NP; p++)
                chk("m_pkt_cnt", 64'(o_pkt_cnt[p*16 +: 16]), 64'(m_pkt[p]));
`endif
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req = '0; last = '0; sel_vld = 1'b0; sel = 4'd0; rdy = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; req = 9'h1FF; last = '0; sel_vld = 1'b1; sel = 4'd0;
        rdy = 1'b1; data = '0;

        // Reset held 3 cycles with every port requesting
        next_cycle();
        chk_en = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        chk("rst_vld",   64'(o_vld),   64'd0);
        chk("rst_grant", 64'(o_grant), 64'd0);
        chk("rst_busy",  64'(o_busy),  64'd0);
        chk("rst_port",  64'(o_port),  64'd0);
        chk("rst_ovf",   64'(o_ovf),   64'd0);
        rst_n = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();

        // Basic 4-beat packet on port 3
        sel = 4'd3; sel_vld = 1'b1; req = 9'h008; data[3*DW +: DW] = 64'hA0;
        #1;
        chk("basic_idle_busy", 64'(o_busy), 64'd0);
        next_cycle();
        sel_vld = 1'b0;
        #1;
        chk("basic_grant", 64'(o_grant), 64'h008);
        chk("basic_busy",  64'(o_busy),  64'd1);
        chk("basic_novld", 64'(o_vld),   64'd0);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            if (i < 4) begin
                data[3*DW +: DW] = 64'hA0 + 64'(i);
                last[3] = (i == 3);
            end else begin
                req = '0; last = '0;
            end
            #1;
            chk("basic_vld",  64'(o_vld),  64'd1);
            chk("basic_data", o_data,      64'hA0 + 64'(i - 1));
            chk("basic_port", 64'(o_port), 64'd3);
            chk("basic_last", 64'(o_last), 64'(i == 4));
            if (i == 4) begin
                chk("basic_release_busy",  64'(o_busy),  64'd0);
                chk("basic_release_grant", 64'(o_grant), 64'd0);
            end
        end
        next_cycle();
        #1;
        chk("basic_drained", 64'(o_vld), 64'd0);

        // Same packet with 3 stalled cycles after the first beat
        sel = 4'd3; sel_vld = 1'b1; req = 9'h008; data[3*DW +: DW] = 64'hA0;
        next_cycle();
        sel_vld = 1'b0;
        #1;
        chk("bp_grant", 64'(o_grant), 64'h008);
        next_cycle();
        rdy = 1'b0; data[3*DW +: DW] = 64'hA1;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) next_cycle();
            #1;
            chk("bp_hold_data",  o_data,       64'hA0);
            chk("bp_hold_vld",   64'(o_vld),   64'd1);
            chk("bp_hold_grant", 64'(o_grant), 64'd0);
        end
        next_cycle();
        rdy = 1'b1;
        #1;
        chk("bp_resume_grant", 64'(o_grant), 64'h008);
        chk("bp_resume_data",  o_data,       64'hA0);
        next_cycle();
        data[3*DW +: DW] = 64'hA2;
        #1;
        chk("bp_data1", o_data, 64'hA1);
        next_cycle();
        data[3*DW +: DW] = 64'hA3; last[3] = 1'b1;
        #1;
        chk("bp_data2", o_data, 64'hA2);
        next_cycle();
        req = '0; last = '0;
        #1;
        chk("bp_data3", o_data,      64'hA3);
        chk("bp_last3", 64'(o_last), 64'd1);
        chk("bp_busy",  64'(o_busy), 64'd0);
        next_cycle();

        // Overrun: port 8 never raises last
        sel = 4'd8; sel_vld = 1'b1; req = 9'h100; data[8*DW +: DW] = 64'hB0;
        next_cycle();
        sel_vld = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            next_cycle();
            if (k < 16) data[8*DW +: DW] = 64'hB0 + 64'(k);
            else req = '0;
            #1;
            if (k <= 16) begin
                chk("ovf_data", o_data,      64'hB0 + 64'(k - 1));
                chk("ovf_last", 64'(o_last), 64'(k == 16));
                chk("ovf_port", 64'(o_port), 64'd8);
            end
            chk("ovf_pulse", 64'(o_ovf), 64'(k == 16));
            if (k == 16) chk("ovf_busy", 64'(o_busy), 64'd0);
            if (k == 17) chk("ovf_drained", 64'(o_vld), 64'd0);
        end

        // Single-beat packet on port 0
        sel = 4'd0; sel_vld = 1'b1; req = 9'h001; last = 9'h001;
        data[0*DW +: DW] = 64'hC0;
        next_cycle();
        sel_vld = 1'b0;
        next_cycle();
        req = '0; last = '0;
        #1;
        chk("single_data", o_data,      64'hC0);
        chk("single_last", 64'(o_last), 64'd1);
        chk("single_busy", 64'(o_busy), 64'd0);
        chk("single_ovf",  64'(o_ovf),  64'd0);
        next_cycle();

        // Invalid selects
        sel = 4'd9; sel_vld = 1'b1; req = 9'h1FF;
        next_cycle();
        sel = 4'd2; req = 9'h1FB;
        #1;
        chk("inv9_busy",  64'(o_busy),  64'd0);
        chk("inv9_grant", 64'(o_grant), 64'd0);
        next_cycle();
        idle_inputs();
        #1;
        chk("inv2_busy",  64'(o_busy),  64'd0);
        chk("inv2_grant", 64'(o_grant), 64'd0);
        next_cycle();

`ifdef PORT9_GRANT_STATS_EN
        chk("stats_p3", 64'(o_pkt_cnt[3*16 +: 16]), 64'd2);
        chk("stats_p8", 64'(o_pkt_cnt[8*16 +: 16]), 64'd1);
        chk("stats_p0", 64'(o_pkt_cnt[0*16 +: 16]), 64'd1);
`endif

        // Reset after beat 2 of a 4-beat packet on port 5
        sel = 4'd5; sel_vld = 1'b1; req = 9'h020; data[5*DW +: DW] = 64'hD0;
        next_cycle();
        sel_vld = 1'b0;
        next_cycle();
        data[5*DW +: DW] = 64'hD1;
        next_cycle();
        data[5*DW +: DW] = 64'hD2;
        rst_n = 1'b0;
        #1;
        chk("mrst_beat2", o_data, 64'hD1);
        next_cycle();
        rst_n = 1'b1; req = '0;
        #1;
        chk("mrst_vld",   64'(o_vld),   64'd0);
        chk("mrst_grant", 64'(o_grant), 64'd0);
        chk("mrst_busy",  64'(o_busy),  64'd0);
`ifdef PORT9_GRANT_STATS_EN
        chk("mrst_stats_p5", 64'(o_pkt_cnt[5*16 +: 16]), 64'd0);
`endif
        next_cycle();

        // Mixed traffic checked by the model only
        for (int c = 0; c < 400; c++) begin
            rst_n   = ($urandom_range(0, 149) != 0);
            req     = NP'($urandom) | NP'($urandom);
            last    = (c < 200) ? NP'($urandom & $urandom) : NP'($urandom & $urandom & $urandom & $urandom);
            sel     = 4'($urandom_range(0, 15));
            sel_vld = ($urandom_range(0, 1) == 1);
            rdy     = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NP; p++) data[p*DW +: DW] = {$urandom, $urandom};
            next_cycle();
        end
        idle_inputs();
        next_cycle();
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/port9_grant_mux.md
Name: port9_grant_mux

Overview:
- Downstream consumer of the 9-way priority encoder in the multi-port data-cache front end.
- Takes the encoder's port select and valid, then locks a grant to that port for one whole packet.
- Muxes the granted port's beats into a single registered output stream with a valid/ready handshake.
- Releases the grant on the last beat, or on a beat-count overrun.

Parameters:
- DWIDTH, 64: data width per port, in bits.
- NPORT, 9: number of requesting ports. Fixed at 9; the select input width is $clog2(NPORT) = 4.
- MAX_BEATS, 16: maximum beats per packet before a forced release. Beat counter width is $clog2(MAX_BEATS+1).

Ports:
- i_clk, input, 1: clock, all logic on the rising edge.
- i_rst_n, input, 1: reset, synchronous, active-low.
- i_req, input, NPORT: per-port beat valid; also the request vector presented to the encoder.
- i_data, input, NPORT*DWIDTH: per-port beat data; port p occupies bits [p*DWIDTH +: DWIDTH].
- i_last, input, NPORT: per-port last-beat flag.
- i_sel_vld, input, 1: encoder valid.
- i_sel, input, 4: encoder selected port index.
- o_grant, output, NPORT: one-hot per-port ready (combinational from state and i_rdy).
- o_vld, output, 1: output beat valid.
- o_data, output, DWIDTH: output beat data.
- o_last, output, 1: output last flag.
- o_port, output, 4: source port of the current output beat.
- i_rdy, input, 1: downstream ready.
- o_busy, output, 1: high while a grant is locked (state BUSY).
- o_ovf, output, 1: one-cycle pulse when an overrun release occurs.

Behaviour:
- Reset (i_rst_n=0 at a clock edge):
  - State goes to IDLE; grant port and beat counter clear to 0.
  - o_vld, o_last, o_ovf, o_busy become 0; o_data and o_port become 0; o_grant is 0.
  - Reset mid-packet drops the grant immediately; any partially sent packet is abandoned with no o_last.
- State IDLE:
  - o_grant is all 0.
  - Arbitration starts when i_sel_vld=1, i_sel<NPORT and i_req[i_sel]=1. The select is latched as gport, the counter is cleared, and the next state is BUSY.
  - If i_sel>=NPORT, or i_req[i_sel]=0, the select is ignored and the block stays IDLE.
- State BUSY:
  - o_busy=1; i_sel and i_sel_vld are ignored.
  - Output register free: ofree = !o_vld || i_rdy.
  - o_grant[gport] = ofree; all other grant bits are 0.
  - A beat is accepted when i_req[gport] && ofree. The output register then loads o_data=i_data[gport], o_last=eff_last and o_port=gport, o_vld goes to 1, and the counter increments.
  - eff_last = i_last[gport] || (cnt == MAX_BEATS-1).
  - On an accepted beat with eff_last=1, the next state is IDLE.
  - If that beat had i_last[gport]=0 (overrun), o_ovf pulses for 1 cycle together with that beat loading.
- Output register:
  - When o_vld=1 and i_rdy=1 with no new beat accepted, o_vld goes to 0.
  - When o_vld=1 and i_rdy=0, o_data, o_last and o_port hold stable.
- Latency:
  - Select accepted at cycle N; state BUSY from cycle N+1.
  - If ofree, o_grant[gport] is asserted in N+1; the first beat appears on o_vld/o_data at N+2.
  - After that, one beat per cycle at full throughput when i_rdy=1.
- Back-to-back packets: the release returns to IDLE, so at least one IDLE cycle separates the last beat of one packet from the grant of the next.
- Single-beat packets: i_last=1 on the first accepted beat produces a 1-beat packet with o_last=1.
- A bubble (i_req[gport]=0 in BUSY) does not release the grant and does not increment the counter.
- Simultaneous events: i_rdy=1 with a new beat accepted in the same cycle keeps o_vld=1 and replaces the register contents.

Optional Feature:
- Macro: PORT9_GRANT_STATS_EN.
- Defined:
  - Adds output o_pkt_cnt, NPORT*16 bits: one saturating 16-bit counter per port.
  - The counter for gport increments on each accepted eff_last beat, including overrun releases.
  - Counters clear on reset and saturate at 16'hFFFF.
- Undefined: the port and the counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold i_rst_n=0 for 3 cycles with i_req=9'h1FF -> o_vld=0, o_grant=0, o_busy=0, o_port=0, o_ovf=0.
- Basic packet: i_sel=3, i_sel_vld=1, i_req[3]=1, i_rdy=1, 4-beat packet with data 0xA0..0xA3 and last on beat 4 -> o_grant=9'h008 from N+1; o_data=A0..A3 on N+2..N+5 with o_port=3 and o_last only on A3; o_busy drops at N+5.
- Backpressure: same packet with i_rdy=0 for 3 cycles after the first beat -> o_data holds A0 and o_grant[3]=0 while stalled; no beat is lost or duplicated.
- Overrun: MAX_BEATS=16, port 8 streams with i_last=0 throughout -> the 16th beat has o_last=1 and o_ovf pulses once; the state returns to IDLE.
- Invalid select: i_sel=9 with i_sel_vld=1, then i_sel=2 with i_req[2]=0 -> the block stays IDLE, o_grant=0 and o_busy=0.
- Mid-packet reset: i_rst_n=0 after beat 2 of a 4-beat packet -> o_vld=0 and o_grant=0 on the next edge; with the macro defined, o_pkt_cnt for that port stays 0.
